// File: rtl/board_map.sv
// board_map: 6x6 submarine game board with map loader, engine query port and BFS read port
module board_map #(
    parameter int WIDTH = 6
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] init_select,
    input  logic       init_load,
    output logic       load_busy,
    input  logic [2:0] mem_x,
    input  logic [2:0] mem_y,
    input  logic       mem_data_in_valid,
    output logic [1:0] mem_data_out,
    output logic       mem_data_out_valid,
    output logic       mem_empty,
    input  logic [2:0] bfs_x,
    input  logic [2:0] bfs_y,
    output logic [1:0] bfs_cell,
    output logic [5:0] ships_left
);
    typedef enum logic {IDLE, LOAD} state_t;
    localparam logic [5:0] MAPS [4][6] = '{
        '{6'h07, 6'h00, 6'h20, 6'h20, 6'h00, 6'h18},
        '{6'h01, 6'h01, 6'h00, 6'h1C, 6'h00, 6'h21},
        '{6'h00, 6'h0E, 6'h00, 6'h00, 6'h30, 6'h01},
        '{6'h21, 6'h00, 6'h00, 6'h00, 6'h00, 6'h21}
    };
    state_t     state, state_n;
    logic [2:0] row_ptr, row_n;
    logic [1:0] sel, sel_n;
    logic [1:0] cells [WIDTH*WIDTH];
    logic [5:0] row_bits;
    logic [2:0] row_cnt;
    logic [5:0] q_idx, b_idx;
    logic       q_in, b_in, q_acc, q_hit;
    logic [1:0] q_cell;
    assign row_bits  = MAPS[sel][row_ptr];
    assign q_in      = (mem_x < 3'(WIDTH)) && (mem_y < 3'(WIDTH));
    assign b_in      = (bfs_x < 3'(WIDTH)) && (bfs_y < 3'(WIDTH));
    assign q_idx     = 6'(mem_x) * 6'(WIDTH) + 6'(mem_y);
    assign b_idx     = 6'(bfs_x) * 6'(WIDTH) + 6'(bfs_y);
    assign q_cell    = q_in ? cells[q_idx] : 2'b00;
    assign bfs_cell  = b_in ? cells[b_idx] : 2'b00;
    assign q_acc     = mem_data_in_valid && (state == IDLE) && !init_load;
    assign q_hit     = q_acc && (q_cell == 2'b01);
    assign load_busy = (state == LOAD);
    assign mem_empty = (ships_left == 6'd0) && !load_busy;
    // number of ships in the row currently being loaded
    always_comb begin
        row_cnt = 3'd0;
        for (int i = 0; i < 6; i++) row_cnt = row_cnt + {2'b00, row_bits[i]};
    end
    // load FSM next state: a load request always restarts, otherwise step through rows 0..5
    always_comb begin
        state_n = state;
        row_n   = row_ptr;
        sel_n   = sel;
        if (init_load) begin
            state_n = LOAD;
            row_n   = 3'd0;
            sel_n   = init_select;
        end else if (state == LOAD) begin
            state_n = (row_ptr == 3'd5) ? IDLE : LOAD;
            row_n   = (row_ptr == 3'd5) ? 3'd0 : row_ptr + 3'd1;
        end
    end
    // load FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            row_ptr <= 3'd0;
            sel     <= 2'd0;
        end else begin
            state   <= state_n;
            row_ptr <= row_n;
            sel     <= sel_n;
        end
    end
    // board array: row writes while loading, ship cells turn to hit on an accepted query
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < WIDTH*WIDTH; i++) cells[i] <= 2'b00;
        end else if (!init_load && state == LOAD) begin
            for (int y = 0; y < 6; y++) cells[6'(row_ptr) * 6'(WIDTH) + 6'(y)] <= {1'b0, row_bits[y]};
        end else if (q_hit) begin
            cells[q_idx] <= 2'b10;
        end
    end
    // intact ship counter: cleared on load request, accumulated per row, decremented per hit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ships_left <= 6'd0;
        else if (init_load) ships_left <= 6'd0;
        else if (state == LOAD) ships_left <= ships_left + {3'b000, row_cnt};
        else if (q_hit) ships_left <= ships_left - 6'd1;
    end
    // query response: pre-update cell value with a one-cycle valid pulse, held between queries
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_data_out       <= 2'b00;
            mem_data_out_valid <= 1'b0;
        end else begin
            mem_data_out_valid <= q_acc;
            if (q_acc) mem_data_out <= q_cell;
        end
    end
endmodule

// File: tb/tb_board_map.sv
// tb_board_map: directed and randomized checks of board_map against a board-level model
module tb_board_map;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] init_select = 2'd0;
    logic       init_load = 1'b0;
    logic       load_busy;
    logic [2:0] mem_x = 3'd0;
    logic [2:0] mem_y = 3'd0;
    logic       mem_data_in_valid = 1'b0;
    logic [1:0] mem_data_out;
    logic       mem_data_out_valid;
    logic       mem_empty;
    logic [2:0] bfs_x = 3'd0;
    logic [2:0] bfs_y = 3'd0;
    logic [1:0] bfs_cell;
    logic [5:0] ships_left;
    int total = 0;
    int bad = 0;
    int bm [6][6];
    int ships = 0;
    int last_out = 0;
    logic [5:0] mm [4][6] = '{
        '{6'h07, 6'h00, 6'h20, 6'h20, 6'h00, 6'h18},
        '{6'h01, 6'h01, 6'h00, 6'h1C, 6'h00, 6'h21},
        '{6'h00, 6'h0E, 6'h00, 6'h00, 6'h30, 6'h01},
        '{6'h21, 6'h00, 6'h00, 6'h00, 6'h00, 6'h21}
    };
    board_map #(.WIDTH(6)) dut (
        .clk(clk), .rstn(rstn), .init_select(init_select), .init_load(init_load),
        .load_busy(load_busy), .mem_x(mem_x), .mem_y(mem_y),
        .mem_data_in_valid(mem_data_in_valid), .mem_data_out(mem_data_out),
        .mem_data_out_valid(mem_data_out_valid), .mem_empty(mem_empty),
        .bfs_x(bfs_x), .bfs_y(bfs_y), .bfs_cell(bfs_cell), .ships_left(ships_left)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    function automatic int mval(input int x, input int y);
        return (x < 6 && y < 6) ? bm[x][y] : 0;
    endfunction
    task automatic mclear();
        for (int x = 0; x < 6; x++) for (int y = 0; y < 6; y++) bm[x][y] = 0;
        ships = 0;
        last_out = 0;
    endtask
    task automatic mload(input int s);
        ships = 0;
        for (int x = 0; x < 6; x++)
            for (int y = 0; y < 6; y++) begin
                bm[x][y] = int'(mm[s][x][y]);
                ships += bm[x][y];
            end
    endtask
    task automatic do_load(input int s, input bit with_q, input string tag);
        int n;
        @(negedge clk);
        init_load = 1'b1;
        init_select = 2'(s);
        mem_data_in_valid = with_q;
        mem_x = 3'd2;
        mem_y = 3'd5;
        @(negedge clk);
        init_load = 1'b0;
        n = 0;
        while (load_busy && n < 20) begin
            chk({tag, "_noval"}, int'(mem_data_out_valid), 0);
            n++;
            @(negedge clk);
        end
        mem_data_in_valid = 1'b0;
        mload(s);
        chk({tag, "_busy_cycles"}, n, 6);
        chk({tag, "_ships"}, int'(ships_left), ships);
        chk({tag, "_empty"}, int'(mem_empty), 0);
    endtask
    task automatic query(input int x, input int y, input string tag);
        int e;
        mem_x = 3'(x);
        mem_y = 3'(y);
        mem_data_in_valid = 1'b1;
        @(negedge clk);
        e = mval(x, y);
        if (e == 1) begin
            bm[x][y] = 2;
            ships--;
        end
        last_out = e;
        chk({tag, "_valid"}, int'(mem_data_out_valid), 1);
        chk({tag, "_data"}, int'(mem_data_out), e);
        chk({tag, "_ships"}, int'(ships_left), ships);
        chk({tag, "_empty"}, int'(mem_empty), int'(ships == 0));
    endtask
    task automatic idle(input string tag);
        mem_data_in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_valid"}, int'(mem_data_out_valid), 0);
        chk({tag, "_hold"}, int'(mem_data_out), last_out);
    endtask
    task automatic bchk(input int x, input int y, input string tag);
        bfs_x = 3'(x);
        bfs_y = 3'(y);
        #1;
        chk(tag, int'(bfs_cell), mval(x, y));
    endtask
    task automatic rst_vals(input string tag);
        int nz;
        nz = 0;
        for (int x = 0; x < 6; x++)
            for (int y = 0; y < 6; y++) begin
                bfs_x = 3'(x);
                bfs_y = 3'(y);
                #1;
                if (bfs_cell !== 2'b00) nz++;
            end
        chk({tag, "_cells"}, nz, 0);
        chk({tag, "_ships"}, int'(ships_left), 0);
        chk({tag, "_empty"}, int'(mem_empty), 1);
        chk({tag, "_busy"}, int'(load_busy), 0);
        chk({tag, "_data"}, int'(mem_data_out), 0);
        chk({tag, "_valid"}, int'(mem_data_out_valid), 0);
    endtask
    initial begin
        mclear();
        repeat (2) @(negedge clk);
        rst_vals("rst");
        @(negedge clk);
        rstn = 1'b1;
        do_load(0, 1'b0, "ld0");
        bchk(0, 2, "bfs_0_2");
        bchk(1, 0, "bfs_1_0");
        @(negedge clk);
        query(2, 5, "q25a");
        query(2, 5, "q25b");
        idle("q25_idle");
        chk("map0_ships_after", int'(ships_left), 6);
        do_load(3, 1'b0, "ld3");
        query(0, 0, "c00");
        query(0, 5, "c05");
        query(5, 0, "c50");
        query(5, 5, "c55");
        idle("corner_idle");
        chk("map3_empty", int'(mem_empty), 1);
        query(3, 3, "q33");
        query(0, 7, "q07");
        query(6, 0, "q60");
        idle("oor_idle");
        do_load(1, 1'b1, "ldq");
        bchk(3, 4, "bfs_3_4");
        bchk(5, 5, "bfs_5_5");
        bchk(7, 0, "bfs_7_0");
        @(negedge clk);
        init_load = 1'b1;
        init_select = 2'd1;
        @(negedge clk);
        init_load = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        mclear();
        #1;
        rst_vals("midrst");
        @(negedge clk);
        rstn = 1'b1;
        do_load(2, 1'b0, "ld2");
        chk("map2_ships", int'(ships_left), 6);
        for (int r = 0; r < 4; r++) begin
            do_load(int'($urandom_range(0, 3)), 1'(r & 1), "rld");
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 3) == 0) idle("ridle");
                else if ($urandom_range(0, 1) == 0) query(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), "rq");
                else query(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), "rqi");
            end
            idle("rend");
            for (int i = 0; i < 6; i++) bchk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), "rbfs");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
